// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry valid/ready pipeline register with a skid slot.
// The main register always drives out_data; the skid register catches the
// word that arrives in the cycle the downstream stalls, so in_ready can be
// a pure register output with no combinational path from out_ready.
module pipe_skid_reg #(
    parameter int              WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       occ_q, occ_d;

    logic accept;
    logic consume;

    // Handshakes are qualified by the registered flags, never by each other.
    assign accept  = in_valid && in_ready_q;
    assign consume = out_valid_q && out_ready;

    // Next-state and data-path selection; flush squashes everything.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_d = in_data;
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end else if (accept) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Status flags are decoded from the next state so they can be registered.
    always_comb begin
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
        case (state_d)
            ST_ONE:  occ_d = 2'd1;
            ST_TWO:  occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    // State and output registers; reset overrides flush and all handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed and random stimulus against a FIFO-queue model.
module tb_pipe_skid_reg;

    localparam int         W    = 8;
    localparam logic [7:0] RVAL = 8'hC3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready = 1'b0;
    logic [1:0]   occupancy;

    int vectors = 0;
    int miscompares = 0;

    pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RVAL)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    // Model: a queue of at most two words in arrival order.
    logic [W-1:0] model_q[$];
    bit           model_known = 0;

    always @(posedge clk) begin
        bit acc;
        bit con;
        if (reset) begin
            model_q.delete();
            model_known = 1;
        end else if (model_known) begin
            if (flush) begin
                model_q.delete();
            end else begin
                acc = in_valid && (model_q.size() < 2);
                con = out_ready && (model_q.size() > 0);
                if (con) void'(model_q.pop_front());
                if (acc) model_q.push_back(in_data);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_known) begin
            check("occupancy", 64'(occupancy), 64'(model_q.size()));
            check("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
            check("in_ready",  64'(in_ready),  64'(model_q.size() < 2));
            if (model_q.size() > 0)
                check("out_data", 64'(out_data), 64'(model_q[0]));
        end
    end

    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [W-1:0] d, input logic ordy);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("step rst=%0b fl=%0b iv=%0b d=%02h ordy=%0b -> occ=%0d ov=%0b ir=%0b od=%02h",
                 rst, fl, iv, d, ordy, occupancy, out_valid, in_ready, out_data);
    endtask

    task automatic expect_lit(input string name, input logic [1:0] occ, input logic ov,
                              input logic ir, input logic [W-1:0] od);
        check({name, ".occ"}, 64'(occupancy), 64'(occ));
        check({name, ".ov"},  64'(out_valid), 64'(ov));
        check({name, ".ir"},  64'(in_ready),  64'(ir));
        check({name, ".od"},  64'(out_data),  64'(od));
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 8'h00, 0);
        expect_lit("reset", 2'd0, 1'b0, 1'b1, RVAL);

        // Streaming at one word per cycle, 1-cycle latency
        step(0, 0, 1, 8'h11, 1);  expect_lit("stream11", 2'd1, 1'b1, 1'b1, 8'h11);
        step(0, 0, 1, 8'h22, 1);  expect_lit("stream22", 2'd1, 1'b1, 1'b1, 8'h22);
        step(0, 0, 1, 8'h33, 1);  expect_lit("stream33", 2'd1, 1'b1, 1'b1, 8'h33);
        step(0, 0, 0, 8'h00, 1);  expect_lit("drain", 2'd0, 1'b0, 1'b1, 8'h33);

        // Stall fills skid, then drains in order
        step(0, 0, 1, 8'hA5, 0);  expect_lit("oneA5", 2'd1, 1'b1, 1'b1, 8'hA5);
        step(0, 0, 1, 8'h5A, 0);  expect_lit("twoA5", 2'd2, 1'b1, 1'b0, 8'hA5);
        step(0, 0, 0, 8'h00, 1);  expect_lit("skid5A", 2'd1, 1'b1, 1'b1, 8'h5A);
        step(0, 0, 0, 8'h00, 1);  expect_lit("empty1", 2'd0, 1'b0, 1'b1, 8'h5A);

        // Word presented while full is ignored
        step(0, 0, 1, 8'h01, 0);
        step(0, 0, 1, 8'h02, 0);
        step(0, 0, 1, 8'hFF, 0);  expect_lit("fullFF", 2'd2, 1'b1, 1'b0, 8'h01);
        step(0, 0, 0, 8'h00, 1);  expect_lit("out02", 2'd1, 1'b1, 1'b1, 8'h02);
        step(0, 0, 0, 8'h00, 1);  expect_lit("noFF", 2'd0, 1'b0, 1'b1, 8'h02);

        // Flush from TWO discards the word presented that cycle
        step(0, 0, 1, 8'h44, 0);
        step(0, 0, 1, 8'h55, 0);
        step(0, 1, 1, 8'h77, 0);  expect_lit("flush", 2'd0, 1'b0, 1'b1, RVAL);
        step(0, 0, 0, 8'h00, 1);  expect_lit("postflush", 2'd0, 1'b0, 1'b1, RVAL);

        // Reset from TWO with out_ready high consumes nothing
        step(0, 0, 1, 8'h66, 0);
        step(0, 0, 1, 8'h67, 0);
        step(1, 0, 0, 8'h00, 1);  expect_lit("resetTWO", 2'd0, 1'b0, 1'b1, RVAL);

        // Reset beats flush and an incoming word
        step(0, 0, 1, 8'h88, 0);
        step(1, 1, 1, 8'h99, 1);  expect_lit("resetprio", 2'd0, 1'b0, 1'b1, RVAL);

        // out_ready while empty has no effect
        step(0, 0, 0, 8'h00, 1);  expect_lit("idle", 2'd0, 1'b0, 1'b1, RVAL);

        // Accept and consume in ONE replaces main in one cycle
        step(0, 0, 1, 8'hB0, 0);
        step(0, 0, 1, 8'hB1, 1);  expect_lit("swap", 2'd1, 1'b1, 1'b1, 8'hB1);
        step(0, 0, 0, 8'h00, 1);

        // Random traffic checked every cycle by the compare process
        for (int i = 0; i < 10000; i++) begin
            reset     = 1'b0;
            flush     = ($urandom_range(0, 199) == 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = 8'($urandom);
            out_ready = $urandom_range(0, 2) != 0;
            @(posedge clk);
            @(negedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 3, payload width in bits (legal range 1..64).
REQ-002 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into both data registers on reset/flush.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush (branch/hazard squash).
REQ-006 SHALL have port in_valid  input  1  upstream has a word on in_data.
REQ-007 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-010 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-011 SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-012 SHALL have port occupancy  output  2  words held (0, 1 or 2).

Function
REQ-013 SHALL hold a main register (drives out_data) and a skid register; states EMPTY (0 words), ONE (main full), TWO (main+skid full).
REQ-014 SHALL accept a word only when in_valid=1 and in_ready=1 in the same cycle; in_valid while in_ready=0 is ignored, no data lost from storage.
REQ-015 SHALL consume a word only when out_valid=1 and out_ready=1 in the same cycle.
REQ-016 SHALL drive in_ready = (state != TWO), out_valid = (state != EMPTY), occupancy = state count, all directly from registers (no combinational in->out paths).
REQ-017 EMPTY: accept -> ONE, main<=in_data; else stay EMPTY.
REQ-018 ONE: accept and consume -> ONE, main<=in_data; consume only -> EMPTY; accept only -> TWO, skid<=in_data; neither -> ONE, hold.
REQ-019 TWO: consume -> ONE, main<=skid; else hold TWO.
REQ-020 SHALL have latency exactly 1 cycle from accept (EMPTY state) to out_valid=1 with that word on out_data.
REQ-021 SHALL preserve word order; no word duplicated or dropped except by flush/reset.
REQ-022 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL sustain one word per cycle throughput when out_ready is held 1.
REQ-024 flush=1 SHALL force next state EMPTY, both registers to RESET_VAL, and discard any word presented that cycle regardless of in_ready.
REQ-025 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-026 reset=1 at a posedge SHALL give state EMPTY, main=skid=RESET_VAL, out_valid=0, in_ready=1, occupancy=0 on the next cycle.
REQ-027 reset SHALL take priority over flush and all handshakes, including mid-transfer in state TWO.
REQ-028 Before the first reset edge, outputs are undefined; nothing downstream SHALL depend on them.

Verification
REQ-029 WIDTH=8: reset, then in_valid=1 with 0x11,0x22,0x33 on consecutive cycles, out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later each, out_valid continuous, occupancy=1.
REQ-030 ONE holding 0xA5, out_ready=0, in_valid=1 data 0x5A -> TWO, in_ready=0, occupancy=2, out_data stays 0xA5; then out_ready=1 -> out_data 0x5A next cycle, in_ready=1.
REQ-031 TWO, in_valid=1 data 0xFF while in_ready=0, then drain with out_ready=1 -> exactly two words out, 0xFF never appears.
REQ-032 TWO, flush=1 with in_valid=1 data 0x77 -> next cycle EMPTY, out_valid=0, out_data=RESET_VAL, in_ready=1; 0x77 never emitted.
REQ-033 TWO, reset=1 and flush=0 with out_ready=1 -> next cycle occupancy=0, out_valid=0, no word consumed.
REQ-034 Random in_valid/out_ready (10k cycles) vs scoreboard queue -> output sequence equals accepted input sequence, occupancy matches queue depth every cycle.
